// File: rtl/vtg_axis_source_if.sv
// rtl/vtg_axis_source_if.sv - AXI4-Stream video bus between the timing generator and its sink
interface vtg_axis_source_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/vtg_axis_source.sv
// rtl/vtg_axis_source.sv - parametrised video timing generator with frame-locked AXI4-Stream master
// Optional internal test patterns selected by defining TEST_PATTERN_EN.
module vtg_axis_source #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int DATA_W    = 24,
  parameter int COORD_W   = 10
) (
  input  logic               pixel_clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  input  logic [DATA_W-1:0]  pix_data,
  input  logic [1:0]         pattern_sel,
  vtg_axis_source_if.master  axis,
  output logic               frame_overrun,
  output logic [7:0]         overrun_count
);
  localparam int H_MAX = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_MAX = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_MAX - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_MAX - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] SX_LAST  = COORD_W'(H_VISIBLE - 1);
  localparam logic [COORD_W-1:0] SY_LAST  = COORD_W'(V_VISIBLE - 1);

  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               hs_act;
  logic               vs_act;
  logic               von_q;

  always_comb begin
    x_nxt = pixel_x + 1'b1;
    y_nxt = pixel_y;
    if (pixel_x == H_LAST) begin
      x_nxt = '0;
      y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
    end
  end

  // Timing flags are computed from the next position so they line up with the counters.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hs_act      <= 1'b0;
      vs_act      <= 1'b0;
      von_q       <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      hs_act      <= (x_nxt >= HS_START) && (x_nxt <= HS_END);
      vs_act      <= (y_nxt >= VS_START) && (y_nxt <= VS_END);
      von_q       <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
      frame_start <= (x_nxt == '0) && (y_nxt == '0);
    end
  end

  assign hsync    = (HSYNC_POL != 0) ? hs_act : ~hs_act;
  assign vsync    = (VSYNC_POL != 0) ? vs_act : ~vs_act;
  assign video_on = von_q & ~reset;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, state_n;
  logic [COORD_W-1:0] sx, sy, sx_n, sy_n;
  logic [DATA_W-1:0]  tdata_n;
  logic               tvalid_n, tuser_n, tlast_n, ovr_n;
  logic [7:0]         cnt_n;
  logic [DATA_W-1:0]  beat_data;

  assign pix_x = sx;
  assign pix_y = sy;

`ifdef TEST_PATTERN_EN
  localparam int CW    = DATA_W / 3;
  localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;

  logic [31:0]   bar_i;
  logic [2:0]    bar;
  logic [CW-1:0] r, g, b, ramp;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps onto the index bits.
  always_comb begin
    bar_i = 32'(sx) / 32'(BAR_W);
    bar   = (bar_i > 32'd7) ? 3'd7 : bar_i[2:0];
    r     = {CW{~bar[1]}};
    g     = {CW{~bar[2]}};
    b     = {CW{~bar[0]}};
    ramp  = CW'(sx);
    case (pattern_sel)
      2'd0:    beat_data = pix_data;
      2'd1:    beat_data = DATA_W'({r, g, b});
      2'd2:    beat_data = DATA_W'({ramp, ramp, ramp});
      default: beat_data = '0;
    endcase
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^pattern_sel;
  assign beat_data          = pix_data;
`endif

  always_comb begin
    state_n  = state;
    sx_n     = sx;
    sy_n     = sy;
    tvalid_n = axis.tvalid;
    tdata_n  = axis.tdata;
    tuser_n  = axis.tuser;
    tlast_n  = axis.tlast;
    ovr_n    = 1'b0;
    cnt_n    = overrun_count;
    if (axis.tvalid && axis.tready) begin
      tvalid_n = 1'b0;
    end
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_n = STREAM;
          sx_n    = '0;
          sy_n    = '0;
        end
      end
      STREAM: begin
        if (frame_start) begin
          ovr_n = 1'b1;
          if (overrun_count != 8'hFF) begin
            cnt_n = overrun_count + 8'd1;
          end
        end
        if (!axis.tvalid || axis.tready) begin
          tvalid_n = 1'b1;
          tdata_n  = beat_data;
          tuser_n  = (sx == '0) && (sy == '0);
          tlast_n  = (sx == SX_LAST);
          if (sx == SX_LAST) begin
            sx_n = '0;
            if (sy == SY_LAST) begin
              sy_n    = '0;
              state_n = IDLE;
            end else begin
              sy_n = sy + 1'b1;
            end
          end else begin
            sx_n = sx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state         <= IDLE;
      sx            <= '0;
      sy            <= '0;
      axis.tvalid   <= 1'b0;
      axis.tdata    <= '0;
      axis.tuser    <= 1'b0;
      axis.tlast    <= 1'b0;
      frame_overrun <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      state         <= state_n;
      sx            <= sx_n;
      sy            <= sy_n;
      axis.tvalid   <= tvalid_n;
      axis.tdata    <= tdata_n;
      axis.tuser    <= tuser_n;
      axis.tlast    <= tlast_n;
      frame_overrun <= ovr_n;
      overrun_count <= cnt_n;
    end
  end
endmodule

// File: tb/tb_vtg_axis_source.sv
// tb/tb_vtg_axis_source.sv - scoreboard bench for vtg_axis_source (two instances: sync polarity high and low)
module tb_vtg_axis_source;
  localparam int HV = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VV = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HM = HV + HFP + HS + HBP;
  localparam int VM = VV + VFP + VS + VBP;
  localparam int FRAME = HM * VM;
  localparam int NBEAT = HV * VV;

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b1;
  logic       tready = 1'b1;
  logic [1:0] pattern_sel = 2'd0;

  always #5 pixel_clk = ~pixel_clk;

  logic        hsync_a, vsync_a, video_on_a, frame_start_a, frame_overrun_a;
  logic [9:0]  pixel_x_a, pixel_y_a, pix_x_a, pix_y_a;
  logic [23:0] pix_data_a;
  logic [7:0]  overrun_count_a;
  logic        hsync_b, vsync_b, video_on_b, frame_start_b, frame_overrun_b;
  logic [9:0]  pixel_x_b, pixel_y_b, pix_x_b, pix_y_b;
  logic [23:0] pix_data_b;
  logic [7:0]  overrun_count_b;

  vtg_axis_source_if #(.DATA_W(24)) axis_a ();
  vtg_axis_source_if #(.DATA_W(24)) axis_b ();

  assign axis_a.tready = tready;
  assign axis_b.tready = tready;
  assign pix_data_a    = {4'b0, pix_y_a, pix_x_a};
  assign pix_data_b    = {4'b0, pix_y_b, pix_x_b};

  vtg_axis_source #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1), .VSYNC_POL(1), .DATA_W(24), .COORD_W(10)
  ) dut_a (
    .pixel_clk(pixel_clk), .reset(reset), .hsync(hsync_a), .vsync(vsync_a),
    .video_on(video_on_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
    .frame_start(frame_start_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .pix_data(pix_data_a), .pattern_sel(pattern_sel), .axis(axis_a),
    .frame_overrun(frame_overrun_a), .overrun_count(overrun_count_a)
  );

  vtg_axis_source #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(0), .VSYNC_POL(0), .DATA_W(24), .COORD_W(10)
  ) dut_b (
    .pixel_clk(pixel_clk), .reset(reset), .hsync(hsync_b), .vsync(vsync_b),
    .video_on(video_on_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
    .frame_start(frame_start_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .pix_data(pix_data_b), .pattern_sel(pattern_sel), .axis(axis_b),
    .frame_overrun(frame_overrun_b), .overrun_count(overrun_count_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] beat_data(input int i, input logic [1:0] sel);
    int x, y;
    x = i % HV;
    y = i / HV;
    case (sel)
      2'd1: begin
        case (x)
          0: beat_data = 24'hFFFFFF;
          1: beat_data = 24'hFFFF00;
          2: beat_data = 24'h00FFFF;
          3: beat_data = 24'h00FF00;
          4: beat_data = 24'hFF00FF;
          5: beat_data = 24'hFF0000;
          6: beat_data = 24'h0000FF;
          default: beat_data = 24'h000000;
        endcase
      end
      2'd2: beat_data = {3{8'(x)}};
      2'd3: beat_data = 24'h0;
      default: beat_data = 24'((y * 1024) + x);
    endcase
  endfunction

  // Reference model: raster position from cycles since reset, one-entry output stage, frame bookkeeping.
  bit          m_known = 0;
  bit          m_streaming = 0;
  bit          m_valid = 0;
  bit          m_ovr = 0;
  bit          m_rst_edge = 0;
  int          m_t = 0;
  int          m_loaded = 0;
  int          m_ovc = 0;
  bit          m_fs;
  logic [1:0]  m_sel;
  beat_t       m_b;
  beat_t       exp_q[$];

  always @(posedge pixel_clk) begin
    if (reset) begin
      m_known     = 1;
      m_t         = 0;
      m_streaming = 0;
      m_loaded    = 0;
      m_valid     = 0;
      m_ovc       = 0;
      m_ovr       = 0;
      m_rst_edge  = 1;
      exp_q.delete();
    end else if (m_known) begin
      m_fs       = (m_t % FRAME) == 0;
      m_rst_edge = 0;
      m_ovr      = 0;
      if (m_streaming) begin
        if (m_fs) begin
          m_ovr = 1;
          if (m_ovc < 255) m_ovc++;
        end
        if (!m_valid || tready) begin
          m_valid = 1;
          m_loaded++;
          if (m_loaded == NBEAT) m_streaming = 0;
        end
      end else begin
        if (m_valid && tready) m_valid = 0;
        if (m_fs) begin
          m_streaming = 1;
          m_loaded    = 0;
`ifdef TEST_PATTERN_EN
          m_sel = pattern_sel;
`else
          m_sel = 2'd0;
`endif
          for (int i = 0; i < NBEAT; i++) begin
            m_b.data = beat_data(i, m_sel);
            m_b.user = (i == 0);
            m_b.last = ((i % HV) == HV - 1);
            exp_q.push_back(m_b);
          end
        end
      end
      m_t++;
    end
  end

  int          mx, my;
  bit          exp_hs, exp_vs;
  beat_t       e;
  bit          prev_stall = 0;
  logic [23:0] prev_data;
  logic        prev_user, prev_last;

  always @(negedge pixel_clk) begin
    if (m_known) begin
      mx     = m_t % HM;
      my     = (m_t / HM) % VM;
      exp_hs = (mx >= HV + HFP) && (mx < HV + HFP + HS);
      exp_vs = (my >= VV + VFP) && (my < VV + VFP + VS);
      check("pixel_x", 32'(pixel_x_a), 32'(mx));
      check("pixel_y", 32'(pixel_y_a), 32'(my));
      check("hsync", 32'(hsync_a), 32'(exp_hs));
      check("vsync", 32'(vsync_a), 32'(exp_vs));
      check("video_on", 32'(video_on_a), 32'((mx < HV) && (my < VV) && !reset));
      check("frame_start", 32'(frame_start_a), 32'((mx == 0) && (my == 0)));
      check("tvalid", 32'(axis_a.tvalid), 32'(m_valid));
      check("frame_overrun", 32'(frame_overrun_a), 32'(m_ovr));
      check("overrun_count", 32'(overrun_count_a), 32'(m_ovc));
      check("pixel_x_neg", 32'(pixel_x_b), 32'(mx));
      check("hsync_neg", 32'(hsync_b), 32'(!exp_hs));
      check("vsync_neg", 32'(vsync_b), 32'(!exp_vs));
      check("tvalid_neg", 32'(axis_b.tvalid), 32'(m_valid));
      if (prev_stall && !m_rst_edge) begin
        check("hold_tdata", 32'(axis_a.tdata), 32'(prev_data));
        check("hold_tuser", 32'(axis_a.tuser), 32'(prev_user));
        check("hold_tlast", 32'(axis_a.tlast), 32'(prev_last));
      end
      if (axis_a.tvalid === 1'b1 && tready) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", 32'(0), 32'(1));
        end else begin
          e = exp_q.pop_front();
          check("tdata", 32'(axis_a.tdata), 32'(e.data));
          check("tuser", 32'(axis_a.tuser), 32'(e.user));
          check("tlast", 32'(axis_a.tlast), 32'(e.last));
          check("tdata_neg", 32'(axis_b.tdata), 32'(e.data));
        end
      end
      prev_stall = (axis_a.tvalid === 1'b1) && !tready;
      prev_data  = axis_a.tdata;
      prev_user  = axis_a.tuser;
      prev_last  = axis_a.tlast;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 4 * FRAME && (m_streaming || m_valid); k++) step(1);
    check(name, 32'(m_streaming || m_valid), 32'(0));
  endtask

  initial begin
    reset       = 1'b1;
    tready      = 1'b1;
    pattern_sel = 2'd0;
    step(3);
    reset = 1'b0;
    step(2 * FRAME);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tready = ((i % 2) == 0);
      step(1);
    end
    tready = 1'b0;
    step(2 * FRAME + 20);
    tready = 1'b1;
    step(2 * FRAME);
    for (int i = 0; i < 3 * FRAME; i++) begin
      tready = 1'($urandom_range(0, 1));
      step(1);
    end
    tready = 1'b0;
    step(258 * FRAME);
    tready = 1'b1;
    step(2 * FRAME);

    tready = 1'b0;
    for (int k = 0; k < 3 * FRAME && !(m_valid && (m_t % HM) == 5); k++) step(1);
    check("stall_before_reset", 32'(m_valid && (m_t % HM) == 5), 32'(1));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_tvalid", 32'(axis_a.tvalid), 32'(0));
    check("rst_pixel_x", 32'(pixel_x_a), 32'(0));
    check("rst_tvalid_neg", 32'(axis_b.tvalid), 32'(0));
    check("rst_hsync_neg", 32'(hsync_b), 32'(1));
    tready = 1'b1;
    step(2 * FRAME);

`ifdef TEST_PATTERN_EN
    wait_idle("idle_before_bars");
    pattern_sel = 2'd1;
    step(2 * FRAME);
    wait_idle("idle_after_bars");
    pattern_sel = 2'd0;
`endif

    wait_idle("drain_idle");
    @(negedge pixel_clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
